// File: rtl/croc_pkg.sv
// Shared SoC types: the address-map rule consumed by every address decoder.
// Latency: n/a, types only.
// Backpressure: n/a.
package croc_pkg;

  typedef struct packed {
    int unsigned idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

// File: rtl/user_pkg.sv
// User-domain address map: subordinate count, offsets/ranges, default rules, demux output ids.
// Latency: n/a, constants only.
// Backpressure: n/a.
package user_pkg;

  import croc_pkg::*;

  localparam int unsigned NumUserDomainSubordinates = 2;

  localparam logic [31:0] UserBaseAddr        = 32'h2000_0000;
  localparam logic [31:0] UserRomAddrOffset   = UserBaseAddr + 32'h0000_0000;
  localparam logic [31:0] UserRomAddrRange    = 32'h0000_1000;
  localparam logic [31:0] UserTimerAddrOffset = UserBaseAddr + 32'h0000_1000;
  localparam logic [31:0] UserTimerAddrRange  = 32'h0000_1000;

  // Demux outputs; UserError is the internal error subordinate and must stay last.
  typedef enum int unsigned {
    UserRom   = 0,
    UserTimer = 1,
    UserError = 2
  } user_demux_outputs_e;

  // Packed-array pattern fills from the highest index down: timer is [1], ROM is [0].
  localparam addr_map_rule_t [NumUserDomainSubordinates-1:0] user_addr_map = '{
    '{idx: 32'(UserTimer), start_addr: UserTimerAddrOffset,
      end_addr: UserTimerAddrOffset + UserTimerAddrRange},
    '{idx: 32'(UserRom), start_addr: UserRomAddrOffset,
      end_addr: UserRomAddrOffset + UserRomAddrRange}
  };

endpackage

// File: rtl/user_addr_demux_err_sbr.sv
// Error subordinate: accepts every request and answers with an error response.
// Latency: response exactly 1 cycle after grant.
// Backpressure: none, grants every cycle so back-to-back errors stream at full rate.
module user_addr_demux_err_sbr #(
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] ErrData   = DataWidth'(32'hBADC_AB1E)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  output logic                 rvalid_o,
  output logic                 err_o,
  output logic [DataWidth-1:0] rdata_o
);

  logic r_rvalid;

  assign gnt_o = 1'b1;

  // One-cycle response pipeline: every accepted request produces a response next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= req_i;
    end
  end

  assign rvalid_o = r_rvalid;
  assign err_o    = r_rvalid;
  assign rdata_o  = r_rvalid ? ErrData : '0;

endmodule

// File: rtl/user_addr_demux.sv
// OBI demux: routes one manager to NumRules subordinates plus an internal error subordinate.
// Latency: 0 cycles request and response path; error responses come 1 cycle after grant.
// Backpressure: stalls when MaxTrans are outstanding or the decode changes target with traffic in flight.
module user_addr_demux
  import user_pkg::*;
#(
  parameter int unsigned          NumRules  = NumUserDomainSubordinates,
  parameter int unsigned          MaxTrans  = 4,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 32,
  parameter logic [DataWidth-1:0] ErrData   = DataWidth'(32'hBADC_AB1E)
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  croc_pkg::addr_map_rule_t [NumRules-1:0]  addr_map_i,
  input  logic                                     mgr_req_i,
  input  logic                                     mgr_we_i,
  input  logic [DataWidth/8-1:0]                   mgr_be_i,
  input  logic [AddrWidth-1:0]                     mgr_addr_i,
  input  logic [DataWidth-1:0]                     mgr_wdata_i,
  output logic                                     mgr_gnt_o,
  output logic                                     mgr_rvalid_o,
  output logic                                     mgr_err_o,
  output logic [DataWidth-1:0]                     mgr_rdata_o,
  output logic [NumRules-1:0]                      sbr_req_o,
  output logic                                     sbr_we_o,
  output logic [DataWidth/8-1:0]                   sbr_be_o,
  output logic [AddrWidth-1:0]                     sbr_addr_o,
  output logic [DataWidth-1:0]                     sbr_wdata_o,
  input  logic [NumRules-1:0]                      sbr_gnt_i,
  input  logic [NumRules-1:0]                      sbr_rvalid_i,
  input  logic [NumRules-1:0]                      sbr_err_i,
  input  logic [NumRules-1:0][DataWidth-1:0]       sbr_rdata_i,
  output logic [$clog2(MaxTrans+1)-1:0]            outstanding_o,
  output logic                                     err_hit_o
);

  localparam int unsigned   SelW   = $clog2(NumRules + 1);
  localparam int unsigned   CntW   = $clog2(MaxTrans + 1);
  localparam logic [SelW-1:0] ErrIdx = SelW'(NumRules);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTrans);

  logic [CntW-1:0]      r_cnt;
  logic [SelW-1:0]      r_tgt;
  logic [SelW-1:0]      w_sel;
  logic                 w_sel_gnt;
  logic                 w_stall;
  logic                 w_go;
  logic                 w_hs;
  logic [CntW-1:0]      w_cnt_eff;
  logic                 w_rvalid;
  logic                 w_rerr;
  logic [DataWidth-1:0] w_rdata;
  logic                 w_err_req;
  logic                 w_err_gnt;
  logic                 w_err_rvalid;
  logic                 w_err_err;
  logic [DataWidth-1:0] w_err_rdata;

  // Address decode: walk rules from high to low so the lowest matching index wins.
  always_comb begin
    w_sel = ErrIdx;
    for (int i = int'(NumRules) - 1; i >= 0; i--) begin
      if ((AddrWidth'(addr_map_i[i].start_addr) <= mgr_addr_i) &&
          (mgr_addr_i < AddrWidth'(addr_map_i[i].end_addr)) &&
          (addr_map_i[i].idx < NumRules)) begin
        w_sel = SelW'(addr_map_i[i].idx);
      end
    end
  end

  // Response mux follows the registered target; nothing passes while no transaction is owed.
  always_comb begin
    w_rvalid = 1'b0;
    w_rerr   = 1'b0;
    w_rdata  = '0;
    if (!rst_i && (r_cnt != '0)) begin
      if (r_tgt == ErrIdx) begin
        w_rvalid = w_err_rvalid;
        w_rerr   = w_err_err;
        w_rdata  = w_err_rdata;
      end
      for (int i = 0; i < int'(NumRules); i++) begin
        if (r_tgt == SelW'(i)) begin
          w_rvalid = sbr_rvalid_i[i];
          w_rerr   = sbr_err_i[i];
          w_rdata  = sbr_rdata_i[i];
        end
      end
    end
  end

  assign mgr_rvalid_o = w_rvalid;
  assign mgr_err_o    = w_rvalid & w_rerr;
  assign mgr_rdata_o  = w_rvalid ? w_rdata : '0;

  // A response retiring this cycle frees its slot, so a waiting request may go in the same cycle.
  assign w_cnt_eff = r_cnt - CntW'(w_rvalid);
  assign w_stall   = (w_cnt_eff == CntMax) || ((w_cnt_eff != '0) && (w_sel != r_tgt));
  assign w_go      = !rst_i && mgr_req_i && !w_stall;

  // Grant source and one-hot request steering for the decoded target.
  always_comb begin
    w_sel_gnt = w_err_gnt;
    sbr_req_o = '0;
    for (int i = 0; i < int'(NumRules); i++) begin
      if (w_sel == SelW'(i)) begin
        w_sel_gnt    = sbr_gnt_i[i];
        sbr_req_o[i] = w_go;
      end
    end
  end

  assign w_err_req = w_go && (w_sel == ErrIdx);
  assign mgr_gnt_o = w_go && w_sel_gnt;
  assign w_hs      = mgr_gnt_o;

  assign sbr_we_o    = mgr_we_i;
  assign sbr_be_o    = mgr_be_i;
  assign sbr_addr_o  = mgr_addr_i;
  assign sbr_wdata_o = mgr_wdata_i;

  // Outstanding counter and target register; a simultaneous handshake and response cancel out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_tgt <= '0;
    end else begin
      if (w_hs && !w_rvalid) begin
        r_cnt <= r_cnt + CntW'(1);
      end else if (!w_hs && w_rvalid) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_hs) begin
        r_tgt <= w_sel;
      end
    end
  end

  assign outstanding_o = r_cnt;
  // The error subordinate's response flop is high exactly one cycle per error grant.
  assign err_hit_o     = w_err_rvalid;

  user_addr_demux_err_sbr #(
    .DataWidth (DataWidth),
    .ErrData   (ErrData)
  ) u_err_sbr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (w_err_req),
    .gnt_o    (w_err_gnt),
    .rvalid_o (w_err_rvalid),
    .err_o    (w_err_err),
    .rdata_o  (w_err_rdata)
  );

endmodule

// File: tb/tb_user_addr_demux.sv
// Bench for user_addr_demux: directed stimulus, queue-based reference model, literal spot checks.
// Latency: model compares every negedge against combinational outputs.
// Backpressure: subordinate grants/rvalids are driven directly by the stimulus.
module tb_user_addr_demux;

  localparam int NR = 2;
  localparam int MT = 4;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic clk_i = 1'b0;
  logic rst_i;
  croc_pkg::addr_map_rule_t [NR-1:0] map;
  logic            mgr_req, mgr_we;
  logic [3:0]      mgr_be;
  logic [31:0]     mgr_addr, mgr_wdata;
  logic            mgr_gnt_o, mgr_rvalid_o, mgr_err_o;
  logic [31:0]     mgr_rdata_o;
  logic [NR-1:0]   sbr_req_o;
  logic            sbr_we_o;
  logic [3:0]      sbr_be_o;
  logic [31:0]     sbr_addr_o, sbr_wdata_o;
  logic [NR-1:0]   sbr_gnt, sbr_rvalid, sbr_err;
  logic [NR-1:0][31:0] sbr_rdata;
  logic [2:0]      outstanding_o;
  logic            err_hit_o;

  int checks = 0;
  int errors = 0;
  int q[$];
  logic err_due = 1'b0;

  always #5 clk_i = ~clk_i;

  user_addr_demux #(
    .NumRules(NR), .MaxTrans(MT), .AddrWidth(32), .DataWidth(32), .ErrData(ERR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .addr_map_i(map),
    .mgr_req_i(mgr_req), .mgr_we_i(mgr_we), .mgr_be_i(mgr_be),
    .mgr_addr_i(mgr_addr), .mgr_wdata_i(mgr_wdata),
    .mgr_gnt_o(mgr_gnt_o), .mgr_rvalid_o(mgr_rvalid_o), .mgr_err_o(mgr_err_o),
    .mgr_rdata_o(mgr_rdata_o),
    .sbr_req_o(sbr_req_o), .sbr_we_o(sbr_we_o), .sbr_be_o(sbr_be_o),
    .sbr_addr_o(sbr_addr_o), .sbr_wdata_o(sbr_wdata_o),
    .sbr_gnt_i(sbr_gnt), .sbr_rvalid_i(sbr_rvalid), .sbr_err_i(sbr_err),
    .sbr_rdata_i(sbr_rdata),
    .outstanding_o(outstanding_o), .err_hit_o(err_hit_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // First rule in array order whose range holds the address; otherwise the error target.
  function automatic int decode_ref(input logic [31:0] a);
    for (int i = 0; i < NR; i++) begin
      if (a >= map[i].start_addr && a < map[i].end_addr && map[i].idx < NR)
        return int'(map[i].idx);
    end
    return NR;
  endfunction

  // Reference model: in-order queue of outstanding targets, checked every negedge.
  always @(negedge clk_i) begin : model
    int tgt, head, eff;
    logic ex_rv, ex_err, ex_gnt, go;
    logic [31:0] ex_rd;
    logic [NR-1:0] ex_req;
    if (rst_i) begin
      q.delete();
      err_due = 1'b0;
      chk("rst_sbr_req", sbr_req_o, 0);
      chk("rst_gnt", mgr_gnt_o, 0);
      chk("rst_rvalid", mgr_rvalid_o, 0);
      chk("rst_err", mgr_err_o, 0);
      chk("rst_rdata", mgr_rdata_o, 0);
      chk("rst_outstanding", outstanding_o, 0);
      chk("rst_err_hit", err_hit_o, 0);
    end else begin
      tgt = decode_ref(mgr_addr);
      ex_rv = 1'b0; ex_err = 1'b0; ex_rd = '0; head = NR;
      if (q.size() > 0) begin
        head = q[0];
        if (head == NR) begin
          ex_rv = err_due; ex_err = err_due; ex_rd = err_due ? ERR : 32'h0;
        end else begin
          ex_rv  = sbr_rvalid[head];
          ex_err = ex_rv & sbr_err[head];
          ex_rd  = ex_rv ? sbr_rdata[head] : 32'h0;
        end
      end
      eff = q.size() - (ex_rv ? 1 : 0);
      go = mgr_req && !(eff == MT || (eff > 0 && tgt != head));
      ex_gnt = go && ((tgt == NR) ? 1'b1 : sbr_gnt[tgt]);
      ex_req = '0;
      if (go && tgt < NR) ex_req[tgt] = 1'b1;
      chk("m_sbr_req", sbr_req_o, ex_req);
      chk("m_gnt", mgr_gnt_o, ex_gnt);
      chk("m_rvalid", mgr_rvalid_o, ex_rv);
      chk("m_err", mgr_err_o, ex_err);
      chk("m_rdata", mgr_rdata_o, ex_rd);
      chk("m_outstanding", outstanding_o, q.size());
      chk("m_err_hit", err_hit_o, err_due);
      chk("m_bc_addr", sbr_addr_o, mgr_addr);
      chk("m_bc_we", sbr_we_o, mgr_we);
      chk("m_bc_be", sbr_be_o, mgr_be);
      chk("m_bc_wdata", sbr_wdata_o, mgr_wdata);
      if (ex_rv) void'(q.pop_front());
      if (ex_gnt) q.push_back(tgt);
      err_due = ex_gnt && (tgt == NR);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1; map = user_pkg::user_addr_map;
    mgr_req = 0; mgr_we = 0; mgr_be = 4'hF; mgr_addr = '0; mgr_wdata = '0;
    sbr_gnt = '0; sbr_rvalid = '0; sbr_err = '0; sbr_rdata = '0;
    tick(); tick();
    chk("lit_rst_outstanding", outstanding_o, 0);
    rst_i = 1'b0;
    tick();

    // ROM read, immediate grant, rvalid two cycles later
    mgr_req = 1; mgr_addr = 32'h2000_0010; sbr_gnt = 2'b01;
    #1 chk("rom_req", sbr_req_o, 2'b01); chk("rom_gnt", mgr_gnt_o, 1);
    tick(); mgr_req = 0; sbr_gnt = 0;
    #1 chk("rom_out1", outstanding_o, 1); chk("rom_req_drop", sbr_req_o, 0);
    tick(); sbr_rvalid = 2'b01; sbr_rdata[0] = 32'h1234_5678;
    #1 chk("rom_rvalid", mgr_rvalid_o, 1); chk("rom_rdata", mgr_rdata_o, 32'h1234_5678);
    tick(); sbr_rvalid = 0;
    #1 chk("rom_out0", outstanding_o, 0);

    // unmapped access -> error subordinate
    mgr_req = 1; mgr_we = 1; mgr_addr = 32'h3000_0000; mgr_wdata = 32'hCAFE_F00D;
    #1 chk("err_gnt", mgr_gnt_o, 1); chk("err_no_sbr_req", sbr_req_o, 0);
    tick(); mgr_req = 0; mgr_we = 0;
    #1 chk("err_rvalid", mgr_rvalid_o, 1); chk("err_err", mgr_err_o, 1);
    chk("err_rdata", mgr_rdata_o, 32'hBADC_AB1E); chk("err_hit", err_hit_o, 1);
    tick();
    #1 chk("err_hit_once", err_hit_o, 0); chk("err_out0", outstanding_o, 0);

    // back-to-back errors just past the timer range
    mgr_req = 1; mgr_addr = 32'h2000_2000;
    repeat (3) tick();
    #1 chk("err_b2b_gnt", mgr_gnt_o, 1); chk("err_b2b_rvalid", mgr_rvalid_o, 1);
    mgr_req = 0; tick(); tick();

    // five timer requests with MaxTrans=4 and rvalid withheld
    mgr_req = 1; mgr_addr = 32'h2000_1000; sbr_gnt = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1 chk("tmr_gnt", mgr_gnt_o, 1);
      tick();
    end
    #1 chk("tmr_stall", mgr_gnt_o, 0); chk("tmr_out4", outstanding_o, 4);
    tick();
    #1 chk("tmr_stall2", mgr_gnt_o, 0);
    sbr_rvalid = 2'b10; sbr_rdata[1] = 32'h0000_7117;
    #1 chk("tmr_gnt5", mgr_gnt_o, 1); chk("tmr_rv", mgr_rvalid_o, 1);
    tick(); mgr_req = 0; sbr_rvalid = 0;
    #1 chk("tmr_out_held", outstanding_o, 4);
    sbr_rvalid = 2'b10;
    repeat (4) tick();
    sbr_rvalid = 0; sbr_gnt = 0;
    #1 chk("tmr_drained", outstanding_o, 0);

    // target switch: ROM waits for the timer response
    mgr_req = 1; mgr_addr = 32'h2000_1004; sbr_gnt = 2'b11;
    #1 chk("sw_tmr_gnt", mgr_gnt_o, 1);
    tick(); mgr_addr = 32'h2000_0020;
    #1 chk("sw_rom_stall_req", sbr_req_o, 0); chk("sw_rom_stall_gnt", mgr_gnt_o, 0);
    tick();
    #1 chk("sw_rom_stall2", mgr_gnt_o, 0);
    sbr_rvalid = 2'b10;
    #1 chk("sw_rom_req", sbr_req_o, 2'b01); chk("sw_rom_gnt", mgr_gnt_o, 1);
    tick(); mgr_req = 0; sbr_rvalid = 2'b10;
    #1 chk("sw_stray_rvalid", mgr_rvalid_o, 0); chk("sw_out1", outstanding_o, 1);
    tick(); sbr_rvalid = 2'b01; sbr_rdata[0] = 32'hA5A5_0001;
    #1 chk("sw_rom_rdata", mgr_rdata_o, 32'hA5A5_0001);
    tick(); sbr_rvalid = 0; sbr_gnt = 0;
    #1 chk("sw_out0", outstanding_o, 0);

    // reset with two outstanding, then a late response
    mgr_req = 1; mgr_addr = 32'h2000_1000; sbr_gnt = 2'b10;
    tick(); tick(); mgr_req = 0; sbr_gnt = 0;
    #1 chk("rr_out2", outstanding_o, 2);
    rst_i = 1;
    #1 chk("rr_cleared", outstanding_o, 0);
    tick(); rst_i = 0;
    tick(); sbr_rvalid = 2'b10;
    #1 chk("rr_late_rvalid", mgr_rvalid_o, 0); chk("rr_late_out", outstanding_o, 0);
    tick(); sbr_rvalid = 0;
    tick();

    // overlapping rules: lowest array index wins
    map[0] = '{idx: 0, start_addr: 32'h2000_0000, end_addr: 32'h2000_1000};
    map[1] = '{idx: 1, start_addr: 32'h1000_0000, end_addr: 32'h3000_0000};
    mgr_req = 1; mgr_addr = 32'h2000_0000; sbr_gnt = 2'b11;
    #1 chk("ovl_req0", sbr_req_o, 2'b01);
    tick(); mgr_req = 0; sbr_rvalid = 2'b01;
    tick(); sbr_rvalid = 0; mgr_req = 1; mgr_addr = 32'h2800_0000;
    #1 chk("ovl_req1", sbr_req_o, 2'b10);
    tick(); mgr_req = 0; sbr_rvalid = 2'b10; sbr_err = 2'b10;
    #1 chk("ovl_sbr_err", mgr_err_o, 1);
    tick(); sbr_rvalid = 0; sbr_err = 0; sbr_gnt = 0;
    tick();
    map = user_pkg::user_addr_map;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
